alu_uart_frame_intf: RTL
========================

Name: alu_uart_frame_intf

Overview:
Parametrised successor of the UART-to-ALU interface. Operands and result are DATA_SIZE bits wide and carried as several UART bytes. The block assembles operands A and B from multi-byte little-endian frames, then the opcode byte. It captures the ALU result and serialises it back through the UART transmitter byte by byte. It adds an inter-byte receive timeout with an error flag. It sits between uart_rx/uart_tx and the combinational ALU.

Parameters:
BYTE_SIZE, 8, UART word width in bits.
DATA_SIZE, 16, operand/result width; must be an integer multiple of BYTE_SIZE (NB = DATA_SIZE/BYTE_SIZE, 1..8).
OPCODE_SIZE, 6, opcode width; must be <= BYTE_SIZE.
TIMEOUT_CYCLES, 100000, maximum clocks allowed between received bytes inside a frame; 0 disables the timeout.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_rx_done  in  1  byte-received strobe from uart_rx (level or pulse; rising edge is used)
i_rx_data  in  BYTE_SIZE  received byte from uart_rx
i_tx_done  in  1  byte-sent strobe from uart_tx (rising edge is used)
i_alu_result  in  DATA_SIZE  ALU output
o_tx_start  out  1  one-cycle start pulse to uart_tx
o_tx_data  out  BYTE_SIZE  byte to transmit; held stable from o_tx_start until i_tx_done
o_data_A  out  DATA_SIZE  operand A to ALU
o_data_B  out  DATA_SIZE  operand B to ALU
o_data_OPCODE  out  OPCODE_SIZE  opcode to ALU
o_busy  out  1  high in every state except RX_A with byte index 0
o_timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Reset (synchronous, active-high): state=RX_A; byte index=0; timeout counter=0; rx/tx edge registers=0. All outputs are 0. Reset has priority over every other event, including mid-frame and mid-transmit; any partial frame is discarded.
- rx_edge = i_rx_done & ~i_rx_done_q. tx_edge = i_tx_done & ~i_tx_done_q. Both edge registers update every cycle.
- RX_A: on rx_edge, write i_rx_data into A[idx*BYTE_SIZE +: BYTE_SIZE] (byte 0 = LSB). If idx==NB-1, set idx=0 and go to RX_B; otherwise increment idx.
- RX_B: same as RX_A but into B; after the last byte go to RX_OP.
- RX_OP: on rx_edge, OPCODE = i_rx_data[OPCODE_SIZE-1:0]; go to LATCH.
- LATCH: lasts 1 cycle; result register <= i_alu_result; idx=0; go to TX_START.
- TX_START: o_tx_data = result byte idx; o_tx_start=1 for exactly this cycle; go to TX_WAIT.
- TX_WAIT: o_tx_data is held. On tx_edge: if idx==NB-1 go to CLEAN; otherwise increment idx and go to TX_START.
- CLEAN: lasts 1 cycle; clear A, B, OPCODE, result, idx and counter; go to RX_A.
- Latency: the first o_tx_start is asserted 2 cycles after the rx_edge of the opcode byte.
- Each transmitted byte requires its own tx_edge; there is no timeout in TX states.
- Timeout: the counter runs only in RX_A with idx>0, in RX_B and in RX_OP. It clears on every accepted rx_edge. If the counter reaches TIMEOUT_CYCLES-1 with no rx_edge: o_timeout_err pulses for 1 cycle and the state goes to CLEAN. If the terminal count and an rx_edge coincide, the byte wins and no error is raised.
- rx_edge in LATCH, TX_START, TX_WAIT or CLEAN is ignored: no data is stored and no state change occurs. The byte is lost.
- rx_edge and tx_edge in the same cycle: each is handled only by the state that owns it.
- NB==1: the block behaves as the legacy single-byte interface, plus timeout and tx handshake.
- Undefined state encodings go to CLEAN.

Decomposition:
- Shared package alu_uart_pkg: state encoding constants (RX_A, RX_B, RX_OP, LATCH, TX_START, TX_WAIT, CLEAN; 3 bits) and the default BYTE_SIZE.
- One sub-module is natural: edge_detect (1-bit registered rising-edge detector with synchronous reset), instantiated twice for rx and tx.
- The timeout counter stays inline; its width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- DATA_SIZE=16: rx bytes 0x34,0x12,0x78,0x56,0x20; ALU model (A+B) -> A=0x1234, B=0x5678, OPCODE=0x20; tx sequence 0xAC then 0x68, one o_tx_start per byte, then all outputs return to 0.
- Level-held i_rx_done (high for 5 cycles per byte) -> exactly one byte accepted per assertion; frame identical to the previous scenario.
- TIMEOUT_CYCLES=50: send 0x34, then silence for 60 cycles -> o_timeout_err pulses once at cycle 50 after the byte; A=0; next frame decodes correctly.
- Reset asserted during TX_WAIT after the first result byte -> next cycle all outputs 0, state RX_A, no further o_tx_start.
- Extra rx byte 0x99 injected during TX_WAIT -> ignored; result bytes unchanged; following frame starts clean with A byte 0 taken from the next byte.
- DATA_SIZE=8, TIMEOUT_CYCLES=0: bytes 0x05,0x03,0x22 (SUB model) -> single tx byte 0x02; an idle wait of 10^6 cycles mid-frame produces no error.

Source files
------------

// File: rtl/alu_uart_frame_intf_pkg.sv
// Shared definitions for the multi-byte UART <-> ALU framing interface.
package alu_uart_pkg;

    localparam int DEFAULT_BYTE_SIZE = 8;

    // Frame sequencer states; 3'd7 is unused and recovers through CLEAN.
    typedef enum logic [2:0] {
        RX_A     = 3'd0,
        RX_B     = 3'd1,
        RX_OP    = 3'd2,
        LATCH    = 3'd3,
        TX_START = 3'd4,
        TX_WAIT  = 3'd5,
        CLEAN    = 3'd6
    } state_e;

endpackage

// File: rtl/alu_uart_frame_intf_if.sv
// Bundle of UART handshake and ALU operand/result signals around the framer.
// slave: the framer itself. master: the UART/ALU side that drives it.
interface alu_uart_frame_intf_if #(
    parameter int BYTE_SIZE   = 8,
    parameter int DATA_SIZE   = 16,
    parameter int OPCODE_SIZE = 6
) ();

    logic                   i_rx_done;
    logic [BYTE_SIZE-1:0]   i_rx_data;
    logic                   i_tx_done;
    logic [DATA_SIZE-1:0]   i_alu_result;
    logic                   o_tx_start;
    logic [BYTE_SIZE-1:0]   o_tx_data;
    logic [DATA_SIZE-1:0]   o_data_A;
    logic [DATA_SIZE-1:0]   o_data_B;
    logic [OPCODE_SIZE-1:0] o_data_OPCODE;
    logic                   o_busy;
    logic                   o_timeout_err;

    modport slave (
        input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        output o_tx_start, o_tx_data, o_data_A, o_data_B, o_data_OPCODE,
               o_busy, o_timeout_err
    );

    modport master (
        output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        input  o_tx_start, o_tx_data, o_data_A, o_data_B, o_data_OPCODE,
               o_busy, o_timeout_err
    );

endinterface

// File: rtl/alu_uart_frame_intf_edge_detect.sv
// Registered rising-edge detector; lets the framer accept pulse or level strobes.
module edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_edge
);

    logic sig_q;

    // Remember last cycle's level so a held strobe yields a single edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_edge = i_sig & ~sig_q;

endmodule

// File: rtl/alu_uart_frame_intf.sv
// Multi-byte UART <-> ALU framer: gathers little-endian operands A and B plus an
// opcode byte, latches the ALU result and sends it back LSB first, one byte per
// uart_tx handshake. An inter-byte receive timeout aborts stalled frames.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RX_A     | collecting operand A bytes (idle when idx == 0)
//   RX_B     | collecting operand B bytes
//   RX_OP    | waiting for the opcode byte
//   LATCH    | capture ALU result, prime first tx byte
//   TX_START | o_tx_start high for this single cycle
//   TX_WAIT  | tx byte held until uart_tx reports done
//   CLEAN    | wipe operands/result, return to idle
module alu_uart_frame_intf
    import alu_uart_pkg::*;
#(
    parameter int BYTE_SIZE      = DEFAULT_BYTE_SIZE,
    parameter int DATA_SIZE      = 16,
    parameter int OPCODE_SIZE    = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_uart_frame_intf_if.slave bus
);

    localparam int NB    = DATA_SIZE / BYTE_SIZE;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    // A zero timeout disables the timer; keep a 1-bit counter so widths stay legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_SIZE-1:0]   a_q;
    logic [DATA_SIZE-1:0]   b_q;
    logic [OPCODE_SIZE-1:0] op_q;
    logic [DATA_SIZE-1:0]   result_q;
    logic                   tx_start_q;
    logic [BYTE_SIZE-1:0]   tx_data_q;
    logic                   timeout_err_q;

    logic                   rx_edge;
    logic                   tx_edge;
    logic                   idx_last;
    logic [IDX_W-1:0]       idx_inc;
    logic                   timer_run;
    logic                   timeout_hit;

    edge_detect u_rx_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (bus.i_rx_done),
        .o_edge  (rx_edge)
    );

    edge_detect u_tx_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (bus.i_tx_done),
        .o_edge  (tx_edge)
    );

    assign idx_last = (idx_q == IDX_LAST);
    assign idx_inc  = idx_q + 1'b1;

    // The timer only guards the gaps inside a frame, never the idle state or tx.
    assign timer_run   = (TIMEOUT_CYCLES != 0) &&
                         (((state_q == RX_A) && (idx_q != '0)) ||
                          (state_q == RX_B) || (state_q == RX_OP));
    // A byte arriving on the terminal count wins over the timeout.
    assign timeout_hit = timer_run && !rx_edge && (cnt_q == CNT_LAST);

    // Frame sequencer with inter-byte timer; all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= RX_A;
            idx_q         <= '0;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            result_q      <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;

            if (timer_run) begin
                if (rx_edge) begin
                    cnt_q <= '0;
                end else if (timeout_hit) begin
                    cnt_q         <= '0;
                    timeout_err_q <= 1'b1;
                    state_q       <= CLEAN;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            case (state_q)
                RX_A: begin
                    if (rx_edge) begin
                        a_q[int'(idx_q) * BYTE_SIZE +: BYTE_SIZE] <= bus.i_rx_data;
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= RX_B;
                        end else begin
                            idx_q <= idx_inc;
                        end
                    end
                end
                RX_B: begin
                    if (rx_edge) begin
                        b_q[int'(idx_q) * BYTE_SIZE +: BYTE_SIZE] <= bus.i_rx_data;
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= RX_OP;
                        end else begin
                            idx_q <= idx_inc;
                        end
                    end
                end
                RX_OP: begin
                    if (rx_edge) begin
                        op_q    <= bus.i_rx_data[OPCODE_SIZE-1:0];
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    // Prime byte 0 from the live ALU output so o_tx_start can
                    // rise in the very next cycle.
                    result_q   <= bus.i_alu_result;
                    tx_data_q  <= bus.i_alu_result[BYTE_SIZE-1:0];
                    tx_start_q <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= TX_START;
                end
                TX_START: begin
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_edge) begin
                        if (idx_last) begin
                            state_q <= CLEAN;
                        end else begin
                            idx_q      <= idx_inc;
                            tx_data_q  <= result_q[int'(idx_inc) * BYTE_SIZE +: BYTE_SIZE];
                            tx_start_q <= 1'b1;
                            state_q    <= TX_START;
                        end
                    end
                end
                CLEAN: begin
                    a_q       <= '0;
                    b_q       <= '0;
                    op_q      <= '0;
                    result_q  <= '0;
                    tx_data_q <= '0;
                    idx_q     <= '0;
                    cnt_q     <= '0;
                    state_q   <= RX_A;
                end
                default: begin
                    state_q <= CLEAN;
                end
            endcase
        end
    end

    assign bus.o_tx_start    = tx_start_q;
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_data_A      = a_q;
    assign bus.o_data_B      = b_q;
    assign bus.o_data_OPCODE = op_q;
    assign bus.o_timeout_err = timeout_err_q;
    assign bus.o_busy        = !((state_q == RX_A) && (idx_q == '0));

endmodule
